// File: rtl/ffa_sched_pkg.sv
// ffa_sched_pkg: shared types and constants for the FFA round-robin scheduler.
//   state_t   : scheduler FSM state (INIT sweep / RUN arbitration)
//   CNT_W     : sweep counter width for the default array depth
//   rsp_t     : response payload {data, error} at the default data width
//   width_of  : index width helper that never returns 0
package ffa_sched_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_N = 8;
  localparam int DEF_REQ_N  = 4;
  localparam int CNT_W      = $clog2(DEF_DATA_N);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic                  error;
  } rsp_t;

  // Width needed to index n items; a 1-entry space still gets one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ffa_rr_scheduler_if.sv
// ffa_rr_scheduler_if: requester-side bus of the scheduler.
//   req_valid/req_wr/req_addr/req_wdata : per-requester request (packed)
//   req_ready                           : one-hot0 grant
//   rsp_valid/rsp_data/rsp_error        : registered response, latency 1
// Handshake: a request transfers in the cycle where req_valid[i] & req_ready[i]
// is high; ready may arrive in the same cycle valid rises and valid need not be
// held stable while ready is low. rsp_valid[i] pulses for one cycle, the cycle
// after requester i was granted; there is no response back-pressure.
// master = requester side, slave = scheduler side.
interface ffa_rr_scheduler_if #(
  parameter int REQ_N  = 4,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);

  logic [REQ_N-1:0]        req_valid;
  logic [REQ_N-1:0]        req_wr;
  logic [REQ_N*ADDR_W-1:0] req_addr;
  logic [REQ_N*DATA_W-1:0] req_wdata;
  logic [REQ_N-1:0]        req_ready;
  logic [REQ_N-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic                    rsp_error;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_error
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_error
  );

endinterface

// File: rtl/ffa_rr_arb.sv
// ffa_rr_arb: combinational round-robin picker.
//   req   : request vector
//   ptr   : index with highest priority this cycle
//   grant : one-hot0 winner
//   idx   : encoded winner (0 when no request)
//   any   : at least one request present
// Search order is ptr, ptr+1, ... wrapping at REQ_N.
module ffa_rr_arb
  import ffa_sched_pkg::*;
#(
  parameter  int REQ_N = 4,
  localparam int IDX_W = width_of(REQ_N)
) (
  input  logic [REQ_N-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [REQ_N-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  function automatic int wrap_idx(input int p, input int k);
    return (p + k) % REQ_N;
  endfunction

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < REQ_N; k++) begin
      if (!any && req[wrap_idx(int'(ptr), k)]) begin
        any                         = 1'b1;
        grant[wrap_idx(int'(ptr), k)] = 1'b1;
        idx                         = IDX_W'(wrap_idx(int'(ptr), k));
      end
    end
  end

endmodule

// File: rtl/ffa_rr_scheduler.sv
// ffa_rr_scheduler: shares one single-port flip-flop register array between
// REQ_N requesters.
//   clk, resetn       : clock, synchronous active-low reset
//   bus (slave)       : requester handshake and registered responses
//   init_done         : high while in RUN
//   arr_wr/arr_rd     : array strobes (never both high)
//   arr_addr/arr_din  : array address / write data
//   arr_dout/arr_error: combinational array read data / error
//   dbg_state/dbg_ptr : FSM state and round-robin pointer
// After reset an optional INIT sweep writes zero to every entry so that every
// valid bit is set; RUN then grants at most one request per cycle.
module ffa_rr_scheduler
  import ffa_sched_pkg::*;
#(
  parameter  int DATA_W         = 8,
  parameter  int ADDR_W         = 3,
  parameter  int DATA_N         = 8,
  parameter  int REQ_N          = 4,
  parameter  int CLEAR_ON_RESET = 1,
  localparam int IDX_W          = width_of(REQ_N),
  localparam int CW             = width_of(DATA_N)
) (
  input  logic              clk,
  input  logic              resetn,
  ffa_rr_scheduler_if.slave bus,
  output logic              init_done,
  output logic              arr_wr,
  output logic              arr_rd,
  output logic [ADDR_W-1:0] arr_addr,
  output logic [DATA_W-1:0] arr_din,
  input  logic [DATA_W-1:0] arr_dout,
  input  logic              arr_error,
  output state_t            dbg_state,
  output logic [IDX_W-1:0]  dbg_ptr
);

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? INIT : RUN;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [REQ_N-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_error_q, rsp_error_d;

  logic [REQ_N-1:0]  arb_req;
  logic [REQ_N-1:0]  g_grant;
  logic [IDX_W-1:0]  g_idx;
  logic              g_any;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_wr;
  logic              in_range;

  // Requests are invisible to the arbiter outside RUN, so no grant can leak
  // out during the sweep.
  assign arb_req = (state_q == RUN) ? bus.req_valid : '0;

  ffa_rr_arb #(
    .REQ_N (REQ_N)
  ) u_arb (
    .req   (arb_req),
    .ptr   (ptr_q),
    .grant (g_grant),
    .idx   (g_idx),
    .any   (g_any)
  );

  assign sel_addr  = bus.req_addr[int'(g_idx)*ADDR_W +: ADDR_W];
  assign sel_wdata = bus.req_wdata[int'(g_idx)*DATA_W +: DATA_W];
  assign sel_wr    = bus.req_wr[g_idx];
  assign in_range  = (int'(sel_addr) < DATA_N);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ptr_d         = ptr_q;
    rsp_valid_d   = '0;
    rsp_data_d    = '0;
    rsp_error_d   = 1'b0;
    arr_wr        = 1'b0;
    arr_rd        = 1'b0;
    arr_addr      = '0;
    arr_din       = '0;
    bus.req_ready = '0;

    case (state_q)
      INIT: begin
        arr_wr   = 1'b1;
        arr_addr = ADDR_W'(cnt_q);
        if (cnt_q == CW'(DATA_N - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (g_any) begin
          bus.req_ready = g_grant;
          // An out-of-range access is still granted and answered, but it
          // must not touch the array.
          arr_wr        = sel_wr & in_range;
          arr_rd        = ~sel_wr & in_range;
          arr_addr      = sel_addr;
          arr_din       = sel_wdata;
          rsp_valid_d   = g_grant;
          rsp_error_d   = ~in_range | (~sel_wr & arr_error);
          rsp_data_d    = (in_range & ~sel_wr & ~arr_error) ? arr_dout : '0;
          ptr_d         = (g_idx == IDX_W'(REQ_N - 1)) ? '0 : g_idx + 1'b1;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_error = rsp_error_q;
  assign init_done     = (state_q == RUN);
  assign dbg_state     = state_q;
  assign dbg_ptr       = ptr_q;

endmodule

// File: tb/tb_ffa_rr_scheduler.sv
// tb_ffa_rr_scheduler: checks two scheduler instances, each against its own
// flip-flop array model.
//   dut_a : defaults (8 entries, INIT sweep after reset)
//   dut_b : 6 entries in a 3-bit space, no sweep (unwritten and out-of-range)
module tb_ffa_rr_scheduler;
  import ffa_sched_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn_a = 1'b0;
  logic resetn_b = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs and array models ----------------
  ffa_rr_scheduler_if #(.REQ_N(4), .ADDR_W(3), .DATA_W(8)) if_a ();
  ffa_rr_scheduler_if #(.REQ_N(4), .ADDR_W(3), .DATA_W(8)) if_b ();

  logic       init_done_a, arr_wr_a, arr_rd_a, arr_error_a;
  logic [2:0] arr_addr_a;
  logic [7:0] arr_din_a, arr_dout_a;
  state_t     dbg_state_a;
  logic [1:0] dbg_ptr_a;

  logic       init_done_b, arr_wr_b, arr_rd_b, arr_error_b;
  logic [2:0] arr_addr_b;
  logic [7:0] arr_din_b, arr_dout_b;
  state_t     dbg_state_b;
  logic [1:0] dbg_ptr_b;

  ffa_rr_scheduler #(.DATA_W(8), .ADDR_W(3), .DATA_N(8), .REQ_N(4), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .resetn(resetn_a), .bus(if_a.slave), .init_done(init_done_a),
    .arr_wr(arr_wr_a), .arr_rd(arr_rd_a), .arr_addr(arr_addr_a), .arr_din(arr_din_a),
    .arr_dout(arr_dout_a), .arr_error(arr_error_a), .dbg_state(dbg_state_a), .dbg_ptr(dbg_ptr_a)
  );

  ffa_rr_scheduler #(.DATA_W(8), .ADDR_W(3), .DATA_N(6), .REQ_N(4), .CLEAR_ON_RESET(0)) dut_b (
    .clk(clk), .resetn(resetn_b), .bus(if_b.slave), .init_done(init_done_b),
    .arr_wr(arr_wr_b), .arr_rd(arr_rd_b), .arr_addr(arr_addr_b), .arr_din(arr_din_b),
    .arr_dout(arr_dout_b), .arr_error(arr_error_b), .dbg_state(dbg_state_b), .dbg_ptr(dbg_ptr_b)
  );

  // Array: per-entry valid bit cleared by reset, set by a write; reading an
  // unwritten or out-of-range entry returns 0 with error.
  logic [7:0] mem_a [8];
  logic [7:0] vm_a;
  logic [7:0] mem_b [8];
  logic [7:0] vm_b;

  always @(posedge clk) begin
    if (!resetn_a) vm_a <= '0;
    else if (arr_wr_a) begin mem_a[arr_addr_a] <= arr_din_a; vm_a[arr_addr_a] <= 1'b1; end
    if (!resetn_b) vm_b <= '0;
    else if (arr_wr_b && arr_addr_b < 3'd6) begin mem_b[arr_addr_b] <= arr_din_b; vm_b[arr_addr_b] <= 1'b1; end
  end

  always_comb begin
    arr_dout_a  = (arr_rd_a && vm_a[arr_addr_a]) ? mem_a[arr_addr_a] : 8'h00;
    arr_error_a = arr_rd_a && !vm_a[arr_addr_a];
    arr_dout_b  = (arr_rd_b && arr_addr_b < 3'd6 && vm_b[arr_addr_b]) ? mem_b[arr_addr_b] : 8'h00;
    arr_error_b = arr_rd_b && !(arr_addr_b < 3'd6 && vm_b[arr_addr_b]);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference state ----------------
  logic [7:0] sm [2][8];
  logic       sv [2][8];
  int         ptr_m [2];

  // Scoreboard entries: {rsp_valid[3:0], rsp_t}
  logic [12:0] exp_a_q [$];
  logic [12:0] exp_b_q [$];
  logic [12:0] mon_a_e, mon_b_e;

  always @(posedge clk) begin
    #1;
    if (exp_a_q.size() > 0) begin
      mon_a_e = exp_a_q.pop_front();
      check_eq("a_rsp_valid", if_a.rsp_valid, mon_a_e[12:9]);
      check_eq("a_rsp_data",  if_a.rsp_data,  mon_a_e[8:1]);
      check_eq("a_rsp_error", if_a.rsp_error, mon_a_e[0]);
    end
  end

  always @(posedge clk) begin
    #1;
    if (exp_b_q.size() > 0) begin
      mon_b_e = exp_b_q.pop_front();
      check_eq("b_rsp_valid", if_b.rsp_valid, mon_b_e[12:9]);
      check_eq("b_rsp_data",  if_b.rsp_data,  mon_b_e[8:1]);
      check_eq("b_rsp_error", if_b.rsp_error, mon_b_e[0]);
    end
  end

  function automatic logic [3:0] rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return 4'b0001 << ((p + k) % 4);
    end
    return 4'b0000;
  endfunction

  function automatic logic [11:0] put_a(input int i, input logic [2:0] a);
    return 12'(a) << (i * 3);
  endfunction

  function automatic logic [31:0] put_d(input int i, input logic [7:0] d);
    return 32'(d) << (i * 8);
  endfunction

  function automatic logic [12:0] pack_exp(input logic [3:0] v, input logic [7:0] d, input logic e);
    rsp_t r;
    r.data  = d;
    r.error = e;
    return {v, r};
  endfunction

  // ---------------- driver tasks ----------------
  // One RUN cycle: drive the request just after a falling edge, check the
  // combinational grant and array strobes, queue the expected response.
  task automatic drive(input bit sel, input logic [3:0] vld, input logic [3:0] wr,
                       input logic [11:0] addr, input logic [31:0] wdata,
                       input logic [3:0] exp_rdy);
    logic [3:0] rdy;
    logic       awr, ard;
    logic [2:0] aad, a;
    logic [7:0] adin, ed;
    logic       ee, inr;
    int         w, s, n;
    s = sel ? 1 : 0;
    n = sel ? 6 : 8;
    if (sel) begin
      if_b.req_valid = vld; if_b.req_wr = wr; if_b.req_addr = addr; if_b.req_wdata = wdata;
    end else begin
      if_a.req_valid = vld; if_a.req_wr = wr; if_a.req_addr = addr; if_a.req_wdata = wdata;
    end
    #1;
    if (sel) begin
      rdy = if_b.req_ready; awr = arr_wr_b; ard = arr_rd_b; aad = arr_addr_b; adin = arr_din_b;
    end else begin
      rdy = if_a.req_ready; awr = arr_wr_a; ard = arr_rd_a; aad = arr_addr_a; adin = arr_din_a;
    end
    check_eq("req_ready", rdy, exp_rdy);
    ed = 8'h00;
    ee = 1'b0;
    w  = -1;
    for (int i = 0; i < 4; i++) if (exp_rdy[i]) w = i;
    if (w >= 0) begin
      a   = addr[w*3 +: 3];
      inr = (int'(a) < n);
      check_eq("arr_wr", awr, wr[w] & inr);
      check_eq("arr_rd", ard, ~wr[w] & inr);
      if (inr) check_eq("arr_addr", aad, a);
      if (wr[w]) begin
        ee = ~inr;
        if (inr) begin
          check_eq("arr_din", adin, wdata[w*8 +: 8]);
          sm[s][a] = wdata[w*8 +: 8];
          sv[s][a] = 1'b1;
        end
      end else if (!inr || !sv[s][a]) begin
        ee = 1'b1;
      end else begin
        ed = sm[s][a];
      end
      ptr_m[s] = (w + 1) % 4;
    end else begin
      check_eq("idle_strobes", {awr, ard}, 2'b00);
    end
    if (sel) exp_b_q.push_back(pack_exp(exp_rdy, ed, ee));
    else     exp_a_q.push_back(pack_exp(exp_rdy, ed, ee));
    @(negedge clk);
  endtask

  // Reset DUT A, check reset values, then follow the zero-fill sweep.
  task automatic init_seq_a();
    resetn_a       = 1'b0;
    if_a.req_valid = 4'b1111;
    if_a.req_wr    = 4'b0000;
    if_a.req_addr  = '0;
    if_a.req_wdata = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_state", dbg_state_a, INIT);
    check_eq("rst_ptr", dbg_ptr_a, 2'd0);
    check_eq("rst_rsp_valid", if_a.rsp_valid, 4'b0000);
    check_eq("rst_init_done", init_done_a, 1'b0);
    resetn_a = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check_eq("init_wr", {arr_wr_a, arr_rd_a}, 2'b10);
      check_eq("init_addr", arr_addr_a, k);
      check_eq("init_din", arr_din_a, 8'h00);
      check_eq("init_ready", if_a.req_ready, 4'b0000);
      check_eq("init_done_low", init_done_a, 1'b0);
      exp_a_q.push_back(pack_exp(4'b0000, 8'h00, 1'b0));
      @(negedge clk);
    end
    check_eq("init_done_high", init_done_a, 1'b1);
    check_eq("run_state", dbg_state_a, RUN);
    if_a.req_valid = 4'b0000;
    for (int i = 0; i < 8; i++) begin sm[0][i] = 8'h00; sv[0][i] = 1'b1; end
    ptr_m[0] = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0]  rv, rw;
    logic [11:0] ra;
    logic [31:0] rd;
    if_b.req_valid = '0; if_b.req_wr = '0; if_b.req_addr = '0; if_b.req_wdata = '0;
    for (int i = 0; i < 8; i++) begin sv[1][i] = 1'b0; sm[1][i] = 8'h00; end
    ptr_m[1] = 0;

    init_seq_a();

    // All four requesters valid: strict rotation from pointer 0.
    drive(0, 4'b1111, 4'b0000, 12'h000, 32'h0, 4'b0001);
    drive(0, 4'b1111, 4'b0000, 12'h000, 32'h0, 4'b0010);
    drive(0, 4'b1111, 4'b0000, 12'h000, 32'h0, 4'b0100);
    drive(0, 4'b1111, 4'b0000, 12'h000, 32'h0, 4'b1000);
    drive(0, 4'b1111, 4'b0000, 12'h000, 32'h0, 4'b0001);
    drive(0, 4'b1111, 4'b0000, 12'h000, 32'h0, 4'b0010);

    // Requester 2: write 0xA5 to addr 3, read it back.
    drive(0, 4'b0100, 4'b0100, put_a(2, 3'd3), put_d(2, 8'hA5), 4'b0100);
    drive(0, 4'b0100, 4'b0000, put_a(2, 3'd3), 32'h0, 4'b0100);

    // Move pointer to 2, then only requesters 0 and 3: 3 wins, then 0.
    drive(0, 4'b0010, 4'b0000, 12'h000, 32'h0, 4'b0010);
    check_eq("ptr_at_2", dbg_ptr_a, 2'd2);
    drive(0, 4'b1001, 4'b0000, put_a(3, 3'd3), 32'h0, 4'b1000);
    drive(0, 4'b1001, 4'b0000, put_a(3, 3'd3), 32'h0, 4'b0001);
    drive(0, 4'b0000, 4'b0000, 12'h000, 32'h0, 4'b0000);

    // Random traffic against the reference model.
    for (int t = 0; t < 40; t++) begin
      rv = 4'($urandom_range(0, 15));
      rw = 4'($urandom_range(0, 15));
      ra = 12'($urandom);
      rd = $urandom;
      drive(0, rv, rw, ra, rd, rr_pick(rv, ptr_m[0]));
    end

    // Grant, then reset in the following cycle: response shows once, then is
    // dropped and the scheduler is back in INIT with pointer 0.
    drive(0, 4'b0100, 4'b0000, 12'h000, 32'h0, rr_pick(4'b0100, ptr_m[0]));
    resetn_a       = 1'b0;
    if_a.req_valid = 4'b0000;
    exp_a_q.push_back(pack_exp(4'b0000, 8'h00, 1'b0));
    @(negedge clk);
    check_eq("midrst_state", dbg_state_a, INIT);
    check_eq("midrst_ptr", dbg_ptr_a, 2'd0);
    init_seq_a();
    drive(0, 4'b1111, 4'b0000, 12'h000, 32'h0, 4'b0001);
    drive(0, 4'b0000, 4'b0000, 12'h000, 32'h0, 4'b0000);

    // DUT B: no sweep, 6 entries.
    check_eq("b_rst_state", dbg_state_b, RUN);
    check_eq("b_rst_init_done", init_done_b, 1'b1);
    check_eq("b_rst_rsp_valid", if_b.rsp_valid, 4'b0000);
    resetn_b = 1'b1;
    drive(1, 4'b0010, 4'b0000, put_a(1, 3'd5), 32'h0, 4'b0010);              // unwritten
    drive(1, 4'b0001, 4'b0000, put_a(0, 3'd6), 32'h0, 4'b0001);              // out of range read
    drive(1, 4'b1000, 4'b1000, put_a(3, 3'd7), put_d(3, 8'h77), 4'b1000);    // out of range write
    drive(1, 4'b0100, 4'b0100, put_a(2, 3'd5), put_d(2, 8'h3C), 4'b0100);
    drive(1, 4'b0100, 4'b0000, put_a(2, 3'd5), 32'h0, 4'b0100);
    drive(1, 4'b0000, 4'b0000, 12'h000, 32'h0, 4'b0000);

    @(negedge clk);
    check_eq("queues_drained", exp_a_q.size() + exp_b_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
